// File: rtl/mousetrap_fifo_sync.sv
// Clocked two-phase bundled-data FIFO: a synchronous successor to the MouseTrap latch stage.
// Optional synchronisers on ReqIn/AckOut let it bridge an asynchronous link into a clocked port.
module mousetrap_fifo_sync #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ReqIn,
    input  logic [WIDTH-1:0]             DataIn,
    output logic                         AckIn,
    output logic                         ReqOut,
    output logic [WIDTH-1:0]             DataOut,
    input  logic                         AckOut,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic             w_req_s;
    logic             w_ack_s;
    logic             w_pending;
    logic             w_busy;
    logic             w_write;
    logic             w_read;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ack_in;
    logic             r_req_out;
    logic [WIDTH-1:0] r_dout;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_req_s = ReqIn;
            assign w_ack_s = AckOut;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_req_sync;
            logic [SYNC_STAGES-1:0] r_ack_sync;

            // Shift towards the MSB; the MSB is the fully synchronised phase bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_req_sync <= '0;
                    r_ack_sync <= '0;
                end else begin
                    r_req_sync <= SYNC_STAGES'({r_req_sync, ReqIn});
                    r_ack_sync <= SYNC_STAGES'({r_ack_sync, AckOut});
                end
            end

            assign w_req_s = r_req_sync[SYNC_STAGES-1];
            assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
        end
    endgenerate

    // A phase mismatch on either side is the whole handshake state.
    assign w_pending = (w_req_s != r_ack_in);
    assign w_busy    = (r_req_out != w_ack_s);
    assign w_write   = w_pending && (r_count < FULL_CNT);
    assign w_read    = !w_busy && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_mem[r_wptr] <= DataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ack_in  <= 1'b0;
            r_req_out <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (w_write) begin
                r_wptr   <= r_wptr + PW'(1);
                r_ack_in <= ~r_ack_in;
            end
            if (w_read) begin
                r_dout    <= r_mem[r_rptr];
                r_rptr    <= r_rptr + PW'(1);
                r_req_out <= ~r_req_out;
            end
            // Full test uses the pre-edge count, so a same-cycle read never frees a slot early.
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign AckIn   = r_ack_in;
    assign ReqOut  = r_req_out;
    assign DataOut = r_dout;
    assign Count   = r_count;

endmodule

// File: doc/mousetrap_fifo_sync.md
# mousetrap_fifo_sync

Clocked, parametrised successor to the asynchronous MouseTrap latch stage. It keeps the same two-phase (transition-signalled) bundled-data handshake on both sides and buffers up to DEPTH words. Optional synchroniser flops on the incoming request and acknowledge let it sit between an asynchronous NoC link and a synchronous router or IP port. Unlike the single latch stage, it decouples sender and receiver, reports occupancy, and applies backpressure when full.

## Interface
Parameters:
- WIDTH, 16, bundled-data width.
- DEPTH, 4, storage words excluding the output register; power of two, ≥2.
- SYNC_STAGES, 2, flops on ReqIn and on AckOut; 0 means the signal is used directly (same-clock peer); legal range 0..3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ReqIn  input  1  two-phase request; each toggle announces a new word on DataIn.
- DataIn  input  WIDTH  bundled data; stable from the ReqIn toggle until the matching AckIn toggle.
- AckIn  output  1  two-phase acknowledge to the sender; toggles once per word accepted.
- ReqOut  output  1  two-phase request to the receiver; toggles once per word presented.
- DataOut  output  WIDTH  presented word; stable while ReqOut != synchronised AckOut.
- AckOut  input  1  two-phase acknowledge from the receiver.
- Count  output  $clog2(DEPTH+1)  words held in storage, excluding the word in the DataOut register.

## Operation
- req_s is ReqIn after SYNC_STAGES flops. ack_s is AckOut after SYNC_STAGES flops.
- **Input pending:** req_s != AckIn.
- **Write:** pending and Count < DEPTH.
  - mem[wptr] <= DataIn.
  - wptr increments, wrapping modulo DEPTH.
  - AckIn toggles.
  - DataIn is sampled directly, not synchronised; the bundling constraint guarantees it is stable.
- **Output busy:** ReqOut != ack_s.
- **Read:** not busy and Count > 0.
  - DataOut <= mem[rptr].
  - rptr increments, wrapping modulo DEPTH.
  - ReqOut toggles.
- **Count:** +1 on write only, −1 on read only, unchanged on both or neither.
- **Full:**
  - With Count == DEPTH, no write occurs and AckIn holds; this is the only backpressure.
  - The full check uses the pre-edge Count. A read in the same cycle does not enable a write that cycle.
- **Empty:** with Count == 0, no read occurs. ReqOut and DataOut hold their last values.
- **Ordering:** strict FIFO. Every accepted word is presented exactly once.
- Phase mismatch is the only state; there is no FSM beyond the pointers, Count and the two phase bits.
- **Reset:**
  - On rst = 1 at an edge: wptr, rptr, Count, AckIn, ReqOut, DataOut (all zeros) and all synchroniser flops go to 0.
  - Reset has priority over write and read in the same cycle.
  - Reset mid-operation discards stored and in-flight words. Peers must return their phase to 0 in the same reset window.

## Timing
- All reset values are 0: AckIn = 0, ReqOut = 0, DataOut = 0, Count = 0.
- A ReqIn toggle set up before edge k is seen as pending after edge k+S−1, where S = SYNC_STAGES. For S = 0 it is pending combinationally before edge k.
- **Accept latency:** AckIn toggles at edge k+S when not full.
- **Forward latency:** when the FIFO is empty and the output is idle, DataOut and ReqOut update at edge k+S+1 (write, then read next cycle). There is no combinational bypass.
- **Release latency:** an AckOut toggle before edge m clears busy after edge m+S−1. The next read can occur at edge m+S.
- **Throughput:**
  - With S = 0 and both peers responding in zero cycles, one word per cycle sustained in each direction.
  - With S > 0, the handshake round-trip limits throughput to one word per (S+1) cycles per side.
- AckIn, ReqOut, DataOut and Count are all registered outputs; none has a combinational input path.

## Test plan
- **Reset values:** assert rst for 2 cycles, with ReqIn and AckOut toggling during reset → AckIn = 0, ReqOut = 0, DataOut = 0, Count = 0 throughout and after release.
- **Single word, S = 2:** toggle ReqIn with DataIn = 16'hA5A5 before edge k → AckIn toggles at edge k+2, then ReqOut toggles with DataOut = 16'hA5A5 at edge k+3; toggle AckOut → Count = 0, and no further ReqOut toggle occurs.
- **Fill to full, S = 0, DEPTH = 4:** receiver never acks; send 6 words 1..6 → words 1 is presented; words 2..5 are stored with Count = 4; the word 6 request stays unacknowledged (AckIn unchanged).
  - Ack once → DataOut = 2.
  - Word 6 is accepted only one cycle after Count drops to 3.
- **Simultaneous write and read at Count = 2, S = 0:** both proceed at the same edge → Count stays 2; wptr and rptr both advance.
- **Wrap-around:** stream 20 words with values 0..19 through DEPTH = 4 using random peer delays → received in order 0..19, no duplicates or losses; pointers wrap 5 times.
- **Reset mid-stream:** assert rst with Count = 3 and the output busy → next edge all outputs are 0; after peers reset to phase 0, new word 16'h1234 passes with the nominal latencies.
